// File: rtl/bcd_chain_counter.sv
// bcd_chain_counter: DIGITS cascaded digits, each counting modulo RADIX.
// Supports up/down counting, a synchronous parallel load with per-digit
// clamping, and wrap or saturate behaviour at the end of range.
// An overflow flag is set by any step requested at the end of range and
// stays set until cleared.
//
// Ports:
//   clk        clock; all state updates on the rising edge
//   rst        synchronous active-high reset
//   en         count enable; one step per cycle while high
//   up         direction: 1 increments, 0 decrements
//   wrap_mode  1 wraps at the end of range, 0 saturates
//   load       parallel load strobe; has priority over en
//   load_val   load value, digit 0 in bits [3:0]; nibbles >= RADIX clamp
//   clr_ovf    clears ovf; a set in the same cycle takes precedence
//   cnt        registered count, digit 0 least significant
//   cout       registered one-cycle pulse on wrap (carry or borrow)
//   tc         combinational terminal count for the current direction
//   ovf        registered sticky overflow flag
module bcd_chain_counter #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned RADIX  = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                up,
  input  logic                wrap_mode,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  input  logic                clr_ovf,
  output logic [4*DIGITS-1:0] cnt,
  output logic                cout,
  output logic                tc,
  output logic                ovf
);

  localparam int unsigned DW = 4;
  localparam int unsigned W  = DW * DIGITS;
  localparam logic [DW-1:0] DMAX = DW'(RADIX - 1);

  logic [DIGITS:0] chain;       // chain[k]: every digit below k is at its end value
  logic [W-1:0]    stepped;     // count after one unconditional step
  logic [W-1:0]    load_clamped;
  logic [W-1:0]    cnt_d;
  logic            cout_d;
  logic            ovf_d;
  logic            ovf_set;

  // Single-cycle ripple: a digit steps when all lower digits sit at their end value.
  always_comb begin
    chain[0]     = 1'b1;
    stepped      = cnt;
    load_clamped = '0;
    for (int k = 0; k < int'(DIGITS); k++) begin
      logic [DW-1:0] d;
      logic [DW-1:0] nib;
      logic          at_end;
      d      = cnt[DW*k +: DW];
      nib    = load_val[DW*k +: DW];
      at_end = up ? (d == DMAX) : (d == '0);
      chain[k+1] = chain[k] & at_end;
      if (chain[k]) begin
        if (up) stepped[DW*k +: DW] = (d == DMAX) ? '0 : DW'(d + DW'(1));
        else    stepped[DW*k +: DW] = (d == '0) ? DMAX : DW'(d - DW'(1));
      end
      load_clamped[DW*k +: DW] = (5'(nib) >= 5'(RADIX)) ? DMAX : nib;
    end
  end

  // End of range is exactly the state where the ripple passes every digit.
  assign tc = chain[DIGITS];

  // Next-state selection: load over count; saturate mode holds at the end.
  always_comb begin
    cnt_d   = cnt;
    cout_d  = 1'b0;
    ovf_set = 1'b0;
    if (load) begin
      cnt_d = load_clamped;
    end else if (en) begin
      ovf_set = tc;
      if (!tc || wrap_mode) begin
        cnt_d  = stepped;
        cout_d = tc;
      end
    end
    ovf_d = ovf_set | (ovf & ~clr_ovf);
  end

  // State registers; reset overrides load and en.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      cnt  <= cnt_d;
      cout <= cout_d;
      ovf  <= ovf_d;
    end
  end

endmodule
